// File: rtl/sr_drive_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_drive_pkg
// Purpose  : Shared constants for the SR flip-flop excitation sequencer.
//            Holds the sequencer state encoding and helpers that derive the
//            FIFO entry width and pointer width from the block parameters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sr_drive_pkg;

    // Sequencer state encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    // A FIFO entry is {bit, hold}
    function automatic int entry_width(input int hold_w);
        return hold_w + 1;
    endfunction

    // Pointer index width; the FIFO adds one wrap bit on top of this
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_fifo
// Purpose  : Synchronous command FIFO for the SR excitation sequencer.
//            Pointers carry an extra wrap bit so full and empty are told
//            apart without a separate flag. No write-to-read bypass: a word
//            written at an edge is readable from the following cycle.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            i_push / i_wdata   - write strobe and data (ignored when full)
//            i_pop              - read strobe (ignored when empty)
//            o_rdata            - head-of-queue word
//            o_full / o_empty   - occupancy flags
//            o_count            - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_fifo
    import sr_drive_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [ENTRY_W-1:0]       i_wdata,
    input  logic                     i_pop,
    output logic [ENTRY_W-1:0]       o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               PTR_W  = ptr_width(DEPTH);
    localparam logic [PTR_W:0]   c_FULL = (PTR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [PTR_W:0]     w_count;
    logic               w_push;
    logic               w_pop;

    // Count is the wrap-aware pointer difference of registered pointers
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_count = w_count;
    assign o_full  = (w_count == c_FULL);
    assign o_empty = (w_count == '0);

    // A push while full is dropped even if a pop frees a slot this cycle
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    assign o_rdata = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sr_drive_seq.sv
`default_nettype none
// ============================================================================
// Module   : sr_drive_seq
// Purpose  : Command-driven excitation sequencer for an SR flip-flop.
//            Queued target levels are turned into single-cycle set/reset
//            pulses; the expected flop level is tracked in q_model and the
//            flop's q feedback is checked one cycle after each pulse.
//            Each command takes IDLE, DRIVE, CHECK and hold HOLD cycles.
// Ports    : clk, rst               - clock, asynchronous active-high reset
//            in_valid/in_bit/in_hold- command input (valid/ready)
//            in_ready               - FIFO not full
//            q_fb                   - q of the driven flop
//            err_clr                - clears the sticky error flag
//            s, r                   - registered set/reset pulses
//            q_model                - expected flop level
//            busy                   - command in flight or queued
//            err                    - sticky feedback mismatch flag
// Revision : 1.0 - initial release
// ============================================================================
module sr_drive_seq
    import sr_drive_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic [HOLD_W-1:0] in_hold,
    output logic              in_ready,
    input  logic              q_fb,
    input  logic              err_clr,
    output logic              s,
    output logic              r,
    output logic              q_model,
    output logic              busy,
    output logic              err
);

    localparam int                ENTRY_W   = entry_width(HOLD_W);
    localparam int                PTR_W     = ptr_width(DEPTH);
    localparam logic [HOLD_W-1:0] c_CNT_ONE = HOLD_W'(1);

    logic [1:0]         r_state;
    logic               r_bit;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  r_cnt;
    logic               r_s;
    logic               r_r;
    logic               r_q_model;
    logic               r_err;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic [PTR_W:0]     w_count;
    logic               w_head_bit;
    logic [HOLD_W-1:0]  w_head_hold;

    assign in_ready    = ~w_full;
    assign w_push      = in_valid & in_ready;
    assign w_pop       = (r_state == c_IDLE) & ~w_empty;
    assign w_head_bit  = w_head[HOLD_W];
    assign w_head_hold = w_head[HOLD_W-1:0];

    sr_cmd_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({in_bit, in_hold}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Pulses are computed at the pop edge so they are high exactly during
    // DRIVE; q_model still holds the pre-command level at that point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_bit     <= 1'b0;
            r_hold    <= '0;
            r_cnt     <= '0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_q_model <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_s <= 1'b0;
            r_r <= 1'b0;
            // Clear first so a mismatch in CHECK below overrides it
            if (err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    if (!w_empty) begin
                        r_bit   <= w_head_bit;
                        r_hold  <= w_head_hold;
                        r_s     <= w_head_bit & ~r_q_model;
                        r_r     <= ~w_head_bit & r_q_model;
                        r_state <= c_DRIVE;
                    end
                end
                c_DRIVE: begin
                    r_q_model <= r_bit;
                    r_state   <= c_CHECK;
                end
                c_CHECK: begin
                    if (q_fb != r_q_model) begin
                        r_err <= 1'b1;
                    end
                    if (r_hold != '0) begin
                        r_cnt   <= r_hold;
                        r_state <= c_HOLD;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_HOLD: begin
                    // Counts hold..1, so a full-scale hold never wraps
                    if (r_cnt == c_CNT_ONE) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign s       = r_s;
    assign r       = r_r;
    assign q_model = r_q_model;
    assign err     = r_err;
    assign busy    = (r_state != c_IDLE) || (w_count != '0);

    a_no_s_and_r: assert property (@(posedge clk) disable iff (rst) !(r_s && r_r));

endmodule
`default_nettype wire
